// File: rtl/rtc_bus_pkg.sv
// Shared RTC multiplexed-bus definitions: write-cycle state encoding, default phase timing and register map.
// Pure declarations, so there is no latency or backpressure.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP  = 3'd2,
    DATA = 3'd3,
    REC  = 3'd4
  } wrState_t;

  localparam int DEF_PHASE_CYC = 11;
  localparam int DEF_GAP_CYC   = 3;
  localparam int DEF_REC_CYC   = 4;

  // RTC register map used by the control FSM
  localparam logic [7:0] RTC_REG_SEC  = 8'h20;
  localparam logic [7:0] RTC_REG_MIN  = 8'h21;
  localparam logic [7:0] RTC_REG_HOUR = 8'h22;
  localparam logic [7:0] RTC_REG_DAY  = 8'h23;
  localparam logic [7:0] RTC_REG_CTRL = 8'h2f;

endpackage

// File: rtl/rtc_phase_cnt.sv
// 5-bit loadable down counter that times one bus phase; it saturates at 0 and never wraps.
// cntNext is combinational, so owners can decode registered outputs from it. There is no backpressure.
module rtc_phase_cnt (
  input  logic       clkB2,
  input  logic       resetB2,
  input  logic       load,
  input  logic [4:0] len,
  output logic       zero,
  output logic [4:0] cntNext
);

  logic [4:0] cnt;

  always_comb begin
    if (load)
      cntNext = len;
    else if (cnt == 5'd0)
      cntNext = 5'd0;
    else
      cntNext = cnt - 5'd1;
  end

  always_ff @(posedge clkB2 or posedge resetB2) begin
    if (resetB2)
      cnt <= 5'd0;
    else
      cnt <= cntNext;
  end

  assign zero = (cnt == 5'd0);

endmodule

// File: rtl/rtc_wr_seq.sv
// Sequences one RTC bus write (ADDR, GAP, DATA, REC); done follows start by 2*PHASE+GAP+REC cycles.
// A start that arrives while busy is dropped (no queueing). Pins are registered from next-state decode.
module rtc_wr_seq
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = DEF_PHASE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int REC_CYC   = DEF_REC_CYC
) (
  input  logic       clkB2,
  input  logic       resetB2,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  localparam logic [4:0] PHASE_LEN = 5'(PHASE_CYC - 1);
  localparam logic [4:0] GAP_LEN   = 5'(GAP_CYC - 1);
  localparam logic [4:0] REC_LEN   = 5'(REC_CYC - 1);

  wrState_t   state, stateNext;
  logic       load, zero, accept, phaseNext;
  logic [4:0] len, cntNext;
  logic [7:0] addrQ, dataQ, addrNext, dataNext;

  rtc_phase_cnt uPhaseCnt (
    .clkB2   (clkB2),
    .resetB2 (resetB2),
    .load    (load),
    .len     (len),
    .zero    (zero),
    .cntNext (cntNext)
  );

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    len       = 5'd0;
    case (state)
      IDLE: if (start) begin stateNext = ADDR; load = 1'b1; len = PHASE_LEN; end
      ADDR: if (zero)  begin stateNext = GAP;  load = 1'b1; len = GAP_LEN;   end
      GAP:  if (zero)  begin stateNext = DATA; load = 1'b1; len = PHASE_LEN; end
      DATA: if (zero)  begin stateNext = REC;  load = 1'b1; len = REC_LEN;   end
      REC:  if (zero)  begin stateNext = IDLE; load = 1'b1; len = 5'd0;      end
      default: begin stateNext = IDLE; load = 1'b1; end
    endcase
  end

  assign accept    = (state == IDLE) && start;
  assign addrNext  = accept ? addr  : addrQ;
  assign dataNext  = accept ? wdata : dataQ;
  assign phaseNext = (stateNext == ADDR) || (stateNext == DATA);

  // wr_n is held high on the first (setup) and last (hold) cycle of each phase
  always_ff @(posedge clkB2 or posedge resetB2) begin
    if (resetB2) begin
      state  <= IDLE;
      addrQ  <= 8'h00;
      dataQ  <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_n   <= 1'b1;
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
    end else begin
      state  <= stateNext;
      addrQ  <= addrNext;
      dataQ  <= dataNext;
      busy   <= (stateNext != IDLE);
      done   <= (state == REC) && (stateNext == IDLE);
      cs_n   <= !phaseNext;
      ad_oe  <= phaseNext;
      ad_n   <= (stateNext != ADDR);
      wr_n   <= !(phaseNext && (cntNext != PHASE_LEN) && (cntNext != 5'd0));
      if (stateNext == ADDR)
        ad_out <= addrNext;
      else if (stateNext == DATA)
        ad_out <= dataQ;
      else
        ad_out <= 8'h00;
    end
  end

  assign rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_wr_seq.sv
// Drives a default and a minimum-timing rtc_wr_seq from shared stimulus and checks every pin each cycle
// against per-cycle expected vectors queued when a start is accepted.
module tb_rtc_wr_seq;

  logic       clkB2 = 1'b0;
  logic       resetB2;
  logic       start;
  logic [7:0] addr, wdata;

  logic       busy0, done0, csN0, wrN0, rdN0, adN0, adOe0;
  logic [7:0] adOut0;
  logic       busy1, done1, csN1, wrN1, rdN1, adN1, adOe1;
  logic [7:0] adOut1;

  // {busy, done, cs_n, wr_n, rd_n, ad_n, ad_oe, ad_out}
  typedef logic [14:0] outVec_t;
  localparam outVec_t IDLE_V = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int phaseCyc[2] = '{11, 3};
  int gapCyc[2]   = '{3, 1};
  int recCyc[2]   = '{4, 1};
  outVec_t expQ[2][$];

  always #5 clkB2 = ~clkB2;

  rtc_wr_seq uDut0 (
    .clkB2(clkB2), .resetB2(resetB2), .start(start), .addr(addr), .wdata(wdata),
    .busy(busy0), .done(done0), .cs_n(csN0), .wr_n(wrN0), .rd_n(rdN0),
    .ad_n(adN0), .ad_out(adOut0), .ad_oe(adOe0)
  );

  rtc_wr_seq #(.PHASE_CYC(3), .GAP_CYC(1), .REC_CYC(1)) uDut1 (
    .clkB2(clkB2), .resetB2(resetB2), .start(start), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .cs_n(csN1), .wr_n(wrN1), .rd_n(rdN1),
    .ad_n(adN1), .ad_out(adOut1), .ad_oe(adOe1)
  );

  function automatic outVec_t obsVec(input int k);
    if (k == 0)
      return {busy0, done0, csN0, wrN0, rdN0, adN0, adOe0, adOut0};
    return {busy1, done1, csN1, wrN1, rdN1, adN1, adOe1, adOut1};
  endfunction

  task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pin vectors for one whole write, one entry per cycle from cycle 0 through the done cycle
  task automatic pushTxn(input int k, input logic [7:0] a, input logic [7:0] d);
    int p = phaseCyc[k];
    for (int i = 0; i < p; i++)
      expQ[k].push_back({1'b1, 1'b0, 1'b0, logic'(i == 0 || i == p - 1), 1'b1, 1'b0, 1'b1, a});
    for (int i = 0; i < gapCyc[k]; i++)
      expQ[k].push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
    for (int i = 0; i < p; i++)
      expQ[k].push_back({1'b1, 1'b0, 1'b0, logic'(i == 0 || i == p - 1), 1'b1, 1'b1, 1'b1, d});
    for (int i = 0; i < recCyc[k]; i++)
      expQ[k].push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
    expQ[k].push_back({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
  endtask

  // Check the current cycle, then drive inputs sampled at the next rising edge
  task automatic step(input logic s, input logic [7:0] a, input logic [7:0] d);
    outVec_t e;
    logic    idle[2];
    @(negedge clkB2);
    for (int k = 0; k < 2; k++) begin
      e = (expQ[k].size() != 0) ? expQ[k].pop_front() : IDLE_V;
      chkEq($sformatf("dut%0d_c%0d", k, cyc), 32'(obsVec(k)), 32'(e));
      idle[k] = !e[14];
    end
    start = s;
    addr  = a;
    wdata = d;
    for (int k = 0; k < 2; k++)
      if (s && idle[k]) pushTxn(k, a, d);
    cyc++;
  endtask

  initial begin
    resetB2 = 1'b1;
    start   = 1'b0;
    addr    = 8'h00;
    wdata   = 8'h00;
    repeat (3) step(1'b0, 8'h00, 8'h00);
    resetB2 = 1'b0;
    repeat (10) step(1'b0, 8'h00, 8'h00);

    // Edge 0 samples this start; loop iteration j checks cycle j
    step(1'b1, 8'h21, 8'h59);
    for (int j = 0; j <= 47; j++) begin
      if (j == 5)
        step(1'b1, 8'hA5, 8'h3C);
      else if (j == 20)
        step(1'b1, 8'h5A, 8'hC3);
      else if (j == 29)
        step(1'b1, 8'h22, 8'h7E);
      else
        step(1'b0, 8'h00, 8'h00);
    end

    // Mid-cycle reset during the second write's data phase (cycle 17 of that write)
    #2 resetB2 = 1'b1;
    #1;
    chkEq("rst_async_dut0", 32'(obsVec(0)), 32'(IDLE_V));
    chkEq("rst_async_dut1", 32'(obsVec(1)), 32'(IDLE_V));
    expQ[0].delete();
    expQ[1].delete();
    @(negedge clkB2);
    resetB2 = 1'b0;
    repeat (3) step(1'b0, 8'h00, 8'h00);

    step(1'b1, 8'h30, 8'hC3);
    repeat (40) step(1'b0, 8'h00, 8'h00);
    chkEq("drain_dut0", 32'(expQ[0].size()), 32'd0);
    chkEq("drain_dut1", 32'(expQ[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/rtc_wr_seq.md
# rtc_wr_seq

Write-cycle sequencer for the multiplexed address/data RTC bus. It is the write-side counterpart of the read-window flag generator. On a single-cycle `start` request it latches a register address and data byte. It then drives one complete bus write: an address phase, a bus gap, a data phase and a recovery period, all timed by an internal phase counter. It sits between the control FSM, which issues `start`, and the RTC pin drivers.

## Interface
Parameters:
- `PHASE_CYC`, default 11: cycles per address phase and per data phase. Legal range 3..31.
- `GAP_CYC`, default 3: idle cycles between the address and data phases. Legal range 1..31.
- `REC_CYC`, default 4: idle cycles after the data phase, before `done`. Legal range 1..31.

Ports:
- `clkB2`  in  1  system clock, rising edge.
- `resetB2`  in  1  asynchronous, active-high reset.
- `start`  in  1  write request, sampled only in IDLE.
- `addr`  in  8  RTC register address, latched on the accepted `start`.
- `wdata`  in  8  data byte, latched on the accepted `start`.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of the transaction.
- `cs_n`  out  1  chip select, active low.
- `wr_n`  out  1  write strobe, active low.
- `rd_n`  out  1  read strobe, held at 1 in all states.
- `ad_n`  out  1  0 = address on bus, 1 = data on bus.
- `ad_out`  out  8  bus drive value.
- `ad_oe`  out  1  bus output enable.

## Operation
- States: IDLE, ADDR, GAP, DATA, REC.
- A 5-bit down counter `cnt` times each state. It loads `len-1` on entry and the state exits when `cnt==0`.
- IDLE:
  - `start`=1 moves to ADDR and latches `addr`/`wdata` into `addr_q`/`data_q`.
  - `start`=0 stays in IDLE.
- ADDR (`PHASE_CYC` cycles):
  - `cs_n`=0, `ad_n`=0, `ad_oe`=1, `ad_out`=`addr_q`.
  - `wr_n`=0 except on the first cycle (setup) and the last cycle (hold), where `wr_n`=1.
- GAP (`GAP_CYC` cycles): `cs_n`=1, `wr_n`=1, `ad_oe`=0, `ad_out`=0, `ad_n`=1.
- DATA (`PHASE_CYC` cycles): same as ADDR, with `ad_n`=1 and `ad_out`=`data_q`.
- REC (`REC_CYC` cycles): same outputs as GAP. On exit, go to IDLE and pulse `done` for 1 cycle.
- `start` while `busy`=1 is ignored. It is not queued, and `addr_q`/`data_q` are unchanged.
- `start` in the cycle where `done`=1 is accepted, because the state is IDLE. This gives back-to-back transactions with no dead cycle.
- All outputs are registered, decoded from the next state and next count, so bus pins are glitch-free.

## Timing
- Reset values: `busy`=0, `done`=0, `cs_n`=1, `wr_n`=1, `rd_n`=1, `ad_n`=1, `ad_out`=0, `ad_oe`=0. State is IDLE, `cnt`=0, `addr_q`=0, `data_q`=0.
- Reset is asynchronous. Assertion mid-transaction returns every output to its reset value immediately, with no completion and no `done`.
- Numbering: the edge that samples `start` is edge 0, and the cycle after edge n is cycle n. With defaults:
  - ADDR: cycles 0–10. `wr_n`=0 in cycles 1–9.
  - GAP: cycles 11–13.
  - DATA: cycles 14–24. `wr_n`=0 in cycles 15–23.
  - REC: cycles 25–28.
  - Cycle 29: `done`=1, `busy`=0.
- General latency: `start` to `done` is `2*PHASE_CYC + GAP_CYC + REC_CYC` cycles.
- `wr_n` low width per phase is `PHASE_CYC-2` cycles. Address/data are stable 1 cycle before the `wr_n` fall and 1 cycle after the `wr_n` rise.
- Counter never wraps: the count loads fresh on every state entry and is never decremented below 0.

## Structure
- Shared package `rtc_bus_pkg` contains:
  - the state encoding typedef (IDLE..REC);
  - default phase constants (`PHASE_CYC`/`GAP_CYC`/`REC_CYC`);
  - the RTC register address constants used by the control FSM.
- One sub-module, `rtc_phase_cnt`:
  - a 5-bit loadable down counter;
  - inputs `load`, `len`; output `zero`.
  - The same sub-module is reusable by the read path.
- Top level holds the FSM, the address/data latches and the output registers.

## Test plan
- Reset, then idle 10 cycles → all outputs hold their reset values; `rd_n`=1 throughout.
- `start` with `addr`=0x21, `wdata`=0x59 (defaults):
  - `ad_out`=0x21 with `ad_n`=0 in cycles 0–10, and 0x59 with `ad_n`=1 in cycles 14–24;
  - `wr_n` low in cycles 1–9 and 15–23;
  - `done`=1 only in cycle 29.
- `start` pulses at cycles 5 and 20 with different `addr`/`wdata` → ignored; bus values stay 0x21/0x59.
- `start` asserted in the `done` cycle with `addr`=0x22 → second ADDR phase begins the next cycle showing 0x22; `busy` stays low for exactly 1 cycle.
- `resetB2` asserted mid-cycle at cycle 17 → `cs_n`/`wr_n`/`ad_oe` go inactive immediately; no `done`; a new `start` after release completes normally.
- `PHASE_CYC`=3, `GAP_CYC`=1, `REC_CYC`=1 → `wr_n` low 1 cycle per phase; `done` at cycle 8.
